retire_trace_buf: RTL

Synthesizable retirement-trace buffer that sits directly downstream of the CPU retire point. It captures one record per retired instruction (sub/movl/movh/ld/st/jz/jnz/js/jns) into a FIFO and drains it over a valid/ready trace port. The CPU is never stalled: when the buffer is full, records are dropped and counted. After `halt`, it drains the remaining records and raises `done`.

---
 rtl/trace_pkg.sv | 35 +++
 rtl/trace_fifo.sv | 70 +++++++
 rtl/retire_trace_buf.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types for the retirement trace buffer.
//   kind_e       : retire kind codes as delivered by the CPU retire point
//   trace_rec_t  : one captured trace record (kind, pc, addr, data)
//   buf_state_e  : RUN / DRAIN / DONE states of the buffer controller
//   REC_W        : packed width of trace_rec_t
package trace_pkg;

    localparam int unsigned REC_W = 52;

    typedef enum logic [3:0] {
        KIND_SUB  = 4'd0,
        KIND_MOVL = 4'd1,
        KIND_MOVH = 4'd2,
        KIND_JZ   = 4'd3,
        KIND_JNZ  = 4'd4,
        KIND_JS   = 4'd5,
        KIND_JNS  = 4'd6,
        KIND_LD   = 4'd7,
        KIND_ST   = 4'd8
    } kind_e;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] pc;
        logic [15:0] addr;
        logic [15:0] data;
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } buf_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wrData  : write request and data; honoured when not full, or when
//                   full and a pop is taken in the same cycle
//   pop, rdData   : read request (ignored when empty), head entry
//   full, empty   : occupancy flags
//   count         : number of stored entries (log2(DEPTH)+1 bits)
module trace_fifo #(
    parameter int unsigned WIDTH = 52,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      countQ;
    logic             doPush;
    logic             doPop;

    assign empty  = (countQ == '0);
    assign full   = (countQ == FULL_COUNT);
    assign count  = countQ;
    assign rdData = mem[rdPtr];

    // When full, a simultaneous pop frees the head slot, which is exactly
    // where wrPtr points, so the write lands there as the head moves on.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            countQ <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   countQ <= countQ + 1'b1;
                2'b01:   countQ <= countQ - 1'b1;
                default: countQ <= countQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !rst) begin
            mem[wrPtr] <= wrData;
        end
    end

endmodule

// File: rtl/retire_trace_buf.sv
// Retirement trace buffer: captures one record per retired instruction into
// a FIFO and drains it over a valid/ready trace port. The CPU is never
// stalled; records arriving while the FIFO is full are dropped and counted
// in a saturating drop counter. After halt, the remaining records drain and
// done rises.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   retire_*            : retire-point record inputs (kind, pc, reg/mem/jump)
//   halt                : CPU halted (level or pulse)
//   trace_valid/ready   : trace port handshake
//   trace_kind/pc/addr/data : head record fields
//   drop_count          : records lost to a full FIFO (saturating)
//   done                : halt seen and FIFO drained
//   filter_mask         : per-kind enable, present only with TRACE_FILTER_EN
// Optional build macro: TRACE_FILTER_EN adds filter_mask [8:0].
module retire_trace_buf
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire_valid,
    input  logic [3:0]        retire_kind,
    input  logic [15:0]       retire_pc,
    input  logic [3:0]        retire_reg_addr,
    input  logic [15:0]       retire_reg_data,
    input  logic [15:0]       retire_mem_addr,
    input  logic [15:0]       retire_mem_data,
    input  logic              retire_jump_taken,
    input  logic [15:0]       retire_jump_addr,
    input  logic              halt,
`ifdef TRACE_FILTER_EN
    input  logic [8:0]        filter_mask,
`endif
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [3:0]        trace_kind,
    output logic [15:0]       trace_pc,
    output logic [15:0]       trace_addr,
    output logic [15:0]       trace_data,
    output logic [DROP_W-1:0] drop_count,
    output logic              done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE_ENTRY = (AW+1)'(1);

    buf_state_e  state;
    buf_state_e  nextState;
    trace_rec_t  rec;
    trace_rec_t  head;
    logic        kindKnown;
    logic        kindEnabled;
    logic        pushEnable;
    logic        pushReq;
    logic        popReq;
    logic        pushAccepted;
    logic        dropNow;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [AW:0] fifoCount;
    logic [REC_W-1:0] fifoRdData;
    logic [DROP_W-1:0] dropCountQ;

    // Record formation from the retire inputs.
    always_comb begin
        rec.kind  = retire_kind;
        rec.pc    = retire_pc;
        rec.addr  = '0;
        rec.data  = '0;
        kindKnown = 1'b1;
        case (retire_kind)
            KIND_SUB, KIND_MOVL, KIND_MOVH, KIND_LD: begin
                rec.addr = {12'b0, retire_reg_addr};
                rec.data = retire_reg_data;
            end
            KIND_ST: begin
                rec.addr = retire_mem_addr;
                rec.data = retire_mem_data;
            end
            KIND_JZ, KIND_JNZ, KIND_JS, KIND_JNS: begin
                rec.addr = retire_jump_taken ? retire_jump_addr
                                             : retire_pc + 16'd2;
                rec.data = {15'b0, retire_jump_taken};
            end
            default: begin
                kindKnown = 1'b0;
            end
        endcase
    end

`ifdef TRACE_FILTER_EN
    logic [15:0] maskExt;
    assign maskExt     = {7'b0, filter_mask};
    assign kindEnabled = maskExt[retire_kind];
`else
    assign kindEnabled = 1'b1;
`endif

    // Controller: RUN accepts pushes; DRAIN only pops; DONE is terminal.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        pushEnable = 1'b0;
        done       = 1'b0;
        case (state)
            ST_RUN: begin
                pushEnable = 1'b1;
                if (halt) begin
                    nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Go to DONE on the edge where the FIFO becomes empty so done
                // is visible in the cycle right after the last pop.
                if ((fifoCount == '0) || ((fifoCount == ONE_ENTRY) && popReq)) begin
                    nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                nextState = ST_RUN;
            end
        endcase
    end

    assign popReq       = trace_valid && trace_ready;
    assign pushReq      = retire_valid && kindKnown && kindEnabled && pushEnable;
    assign pushAccepted = pushReq && (!fifoFull || popReq);
    assign dropNow      = pushReq && !pushAccepted;

    always_ff @(posedge clk) begin
        if (rst) begin
            dropCountQ <= '0;
        end else if (dropNow && (dropCountQ != '1)) begin
            dropCountQ <= dropCountQ + 1'b1;
        end
    end

    assign drop_count = dropCountQ;

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (pushAccepted),
        .wrData (rec),
        .pop    (popReq),
        .rdData (fifoRdData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    assign head        = trace_rec_t'(fifoRdData);
    assign trace_valid = !fifoEmpty;
    assign trace_kind  = head.kind;
    assign trace_pc    = head.pc;
    assign trace_addr  = head.addr;
    assign trace_data  = head.data;

endmodule
